// File: rtl/led_scan_ctrl_pkg.sv
// Shared encodings for the LED scan controller: mode, direction and bus widths.
// No logic, so no latency.
// No flow control; pure type and constant definitions.
package led_scan_ctrl_pkg;

  localparam int ADDR_W = 3;
  localparam int DATA_W = 8;

  localparam logic [ADDR_W-1:0] ADDR_ZERO = '0;
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;

  typedef enum logic [1:0] {
    MODE_UP   = 2'b00,
    MODE_DOWN = 2'b01,
    MODE_PING = 2'b10,
    MODE_HOLD = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/led_scan_ctrl_tick.sv
// Prescaler: one-cycle tick every DIV enabled cycles; count clears when disabled.
// Tick is combinational from the count register, asserted in the cycle count==DIV-1.
// No backpressure; a disabled enable holds the count at zero.
module tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  output logic o_tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_tick;

  assign w_tick = i_en && (r_cnt == CNT_LAST);
  assign o_tick = w_tick;

  // Count 0..DIV-1 while enabled; restart on tick or when disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!i_en || w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_scan_ctrl.sv
// Paced ROM address sequencer (up/down/ping-pong/hold) with registered LED output stage.
// LED reflects a new address 2 cycles after rom_addr changes (ROM register + capture).
// No backpressure; en=0 freezes stepping but in-flight fetches still land on the LEDs.
module led_scan_ctrl
  import led_scan_ctrl_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [1:0]        mode,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_dout,
  output logic [DATA_W-1:0] led,
  output logic              led_upd,
  output logic              led_valid,
  output logic              wrap
);

  mode_e             w_mode;
  logic              w_tick;
  dir_e              r_dir;
  dir_e              w_dir_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic              w_step;
  logic              w_wrap;
  logic [1:0]        r_pend;
  logic [DATA_W-1:0] r_led;
  logic              r_led_upd;
  logic              r_led_valid;
  logic              r_wrap;

  assign w_mode = mode_e'(mode);

  tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (en),
    .o_tick (w_tick)
  );

  // Next address, direction and wrap flag for the mode sampled on this tick.
  always_comb begin
    w_addr_nxt = r_addr;
    w_dir_nxt  = r_dir;
    w_step     = 1'b0;
    w_wrap     = 1'b0;
    if (w_tick) begin
      case (w_mode)
        MODE_UP: begin
          w_step     = 1'b1;
          w_addr_nxt = r_addr + ADDR_ONE;
          w_dir_nxt  = DIR_UP;
          w_wrap     = (r_addr == ADDR_MAX);
        end
        MODE_DOWN: begin
          w_step     = 1'b1;
          w_addr_nxt = r_addr - ADDR_ONE;
          w_dir_nxt  = DIR_DOWN;
          w_wrap     = (r_addr == ADDR_ZERO);
        end
        MODE_PING: begin
          w_step = 1'b1;
          if (r_dir == DIR_UP) begin
            if (r_addr == ADDR_MAX) begin
              // Bounce off the top end.
              w_addr_nxt = r_addr - ADDR_ONE;
              w_dir_nxt  = DIR_DOWN;
              w_wrap     = 1'b1;
            end else begin
              w_addr_nxt = r_addr + ADDR_ONE;
            end
          end else begin
            if (r_addr == ADDR_ZERO) begin
              // Bounce off the bottom end.
              w_addr_nxt = r_addr + ADDR_ONE;
              w_dir_nxt  = DIR_UP;
              w_wrap     = 1'b1;
            end else begin
              w_addr_nxt = r_addr - ADDR_ONE;
            end
          end
        end
        default: begin
          // Hold: tick is ignored, nothing fetched.
        end
      endcase
    end
  end

  // Direction state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dir <= DIR_UP;
    end else begin
      r_dir <= w_dir_nxt;
    end
  end

  // Address register and fetch-latency pipe; pend resets to 01 so address 0 loads after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
      r_pend <= 2'b01;
    end else begin
      r_addr <= w_addr_nxt;
      r_pend <= {r_pend[0], w_step};
    end
  end

  // LED capture stage plus registered update/valid/wrap strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_led       <= '0;
      r_led_upd   <= 1'b0;
      r_led_valid <= 1'b0;
      r_wrap      <= 1'b0;
    end else begin
      r_led_upd <= r_pend[1];
      r_wrap    <= w_wrap;
      if (r_pend[1]) begin
        r_led       <= rom_dout;
        r_led_valid <= 1'b1;
      end
    end
  end

  assign rom_addr  = r_addr;
  assign led       = r_led;
  assign led_upd   = r_led_upd;
  assign led_valid = r_led_valid;
  assign wrap      = r_wrap;

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Bench for led_scan_ctrl with a registered one-hot ROM in the loop, DIV=4 and DIV=1 instances.
// Inputs driven and outputs sampled on the falling edge.
// No flow control in the design under test.
module tb_led_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_a_n = 1'b0;
  logic       en_a = 1'b0;
  logic [1:0] mode_a = 2'b00;
  logic [2:0] addr_a;
  logic [7:0] dout_a = 8'h00;
  logic [7:0] led_a;
  logic       upd_a, valid_a, wrap_a;

  logic       rst_b_n = 1'b0;
  logic       en_b = 1'b0;
  logic [1:0] mode_b = 2'b00;
  logic [2:0] addr_b;
  logic [7:0] dout_b = 8'h00;
  logic [7:0] led_b;
  logic       upd_b, valid_b, wrap_b;

  int checks = 0;
  int errors = 0;
  int e = 0;

  always #5 clk = ~clk;

  // One-hot pattern ROMs with one-cycle registered read.
  always @(posedge clk) dout_a <= 8'h01 << addr_a;
  always @(posedge clk) dout_b <= 8'h01 << addr_b;

  led_scan_ctrl #(.DIV(4)) dut_a (
    .clk(clk), .rst_n(rst_a_n), .en(en_a), .mode(mode_a),
    .rom_addr(addr_a), .rom_dout(dout_a), .led(led_a),
    .led_upd(upd_a), .led_valid(valid_a), .wrap(wrap_a)
  );

  led_scan_ctrl #(.DIV(1)) dut_b (
    .clk(clk), .rst_n(rst_b_n), .en(en_b), .mode(mode_b),
    .rom_addr(addr_b), .rom_dout(dout_b), .led(led_b),
    .led_upd(upd_b), .led_valid(valid_b), .wrap(wrap_b)
  );

  task automatic cyc();
    @(negedge clk);
    e++;
  endtask

  task automatic reset_a();
    rst_a_n = 1'b0;
    en_a    = 1'b1;
    mode_a  = 2'b00;
    repeat (2) @(negedge clk);
    rst_a_n = 1'b1;
    e = 0;
  endtask

  task automatic test_reset();
    rst_a_n = 1'b0;
    en_a    = 1'b1;
    mode_a  = 2'b00;
    repeat (2) @(negedge clk);
    checks++; if (addr_a !== 3'd0)  begin errors++; $display("FAIL rst_addr got %0d want 0", addr_a); end
    checks++; if (led_a !== 8'h00)  begin errors++; $display("FAIL rst_led got %h want 00", led_a); end
    checks++; if (upd_a !== 1'b0)   begin errors++; $display("FAIL rst_upd got %b want 0", upd_a); end
    checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", valid_a); end
    checks++; if (wrap_a !== 1'b0)  begin errors++; $display("FAIL rst_wrap got %b want 0", wrap_a); end
    rst_a_n = 1'b1;
    e = 0;
    cyc();
    checks++; if (upd_a !== 1'b0 || valid_a !== 1'b0 || led_a !== 8'h00)
      begin errors++; $display("FAIL first_edge got upd=%b valid=%b led=%h want 0 0 00", upd_a, valid_a, led_a); end
    cyc();
    checks++; if (led_a !== 8'h01 || upd_a !== 1'b1 || valid_a !== 1'b1)
      begin errors++; $display("FAIL second_edge got led=%h upd=%b valid=%b want 01 1 1", led_a, upd_a, valid_a); end
  endtask

  task automatic test_up();
    logic [2:0] exp_addr;
    logic [7:0] exp_led;
    logic       exp_upd, exp_wrap;
    for (int i = 3; i <= 34; i++) begin
      cyc();
      exp_addr = 3'((e / 4) % 8);
      exp_led  = 8'h01 << ((e - 2) / 4 % 8);
      exp_upd  = (e % 4 == 2);
      exp_wrap = (e == 32);
      checks++; if (addr_a !== exp_addr) begin errors++; $display("FAIL up_addr e=%0d got %0d want %0d", e, addr_a, exp_addr); end
      checks++; if (led_a !== exp_led)   begin errors++; $display("FAIL up_led e=%0d got %h want %h", e, led_a, exp_led); end
      checks++; if (upd_a !== exp_upd)   begin errors++; $display("FAIL up_upd e=%0d got %b want %b", e, upd_a, exp_upd); end
      checks++; if (wrap_a !== exp_wrap) begin errors++; $display("FAIL up_wrap e=%0d got %b want %b", e, wrap_a, exp_wrap); end
    end
    checks++; if (valid_a !== 1'b1) begin errors++; $display("FAIL up_valid got %b want 1", valid_a); end
  endtask

  task automatic test_down();
    logic [2:0] t_addr [8] = '{3'd0, 3'd7, 3'd7, 3'd7, 3'd7, 3'd6, 3'd6, 3'd6};
    logic       t_wrap [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       t_upd  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [7:0] t_led  [8] = '{8'h01, 8'h01, 8'h01, 8'h80, 8'h80, 8'h80, 8'h80, 8'h40};
    mode_a = 2'b01;
    for (int i = 0; i < 8; i++) begin
      cyc();
      checks++; if (addr_a !== t_addr[i]) begin errors++; $display("FAIL down_addr e=%0d got %0d want %0d", e, addr_a, t_addr[i]); end
      checks++; if (wrap_a !== t_wrap[i]) begin errors++; $display("FAIL down_wrap e=%0d got %b want %b", e, wrap_a, t_wrap[i]); end
      checks++; if (upd_a !== t_upd[i])   begin errors++; $display("FAIL down_upd e=%0d got %b want %b", e, upd_a, t_upd[i]); end
      checks++; if (led_a !== t_led[i])   begin errors++; $display("FAIL down_led e=%0d got %h want %h", e, led_a, t_led[i]); end
    end
  endtask

  task automatic test_ping();
    logic [2:0] pp_addr [11] = '{3'd6, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd1, 3'd2};
    logic       pp_wrap [11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0] exp_led;
    reset_a();
    while (e < 20) cyc();
    checks++; if (addr_a !== 3'd5) begin errors++; $display("FAIL ping_start got %0d want 5", addr_a); end
    mode_a = 2'b10;
    while (e < 23) begin
      cyc();
      if (e == 22) begin
        checks++; if (led_a !== 8'h20 || upd_a !== 1'b1) begin errors++; $display("FAIL ping_pre_led got %h/%b want 20/1", led_a, upd_a); end
      end
    end
    for (int k = 0; k < 11; k++) begin
      exp_led = 8'h01 << pp_addr[k];
      cyc();
      checks++; if (addr_a !== pp_addr[k]) begin errors++; $display("FAIL ping_addr k=%0d got %0d want %0d", k, addr_a, pp_addr[k]); end
      checks++; if (wrap_a !== pp_wrap[k]) begin errors++; $display("FAIL ping_wrap k=%0d got %b want %b", k, wrap_a, pp_wrap[k]); end
      cyc();
      checks++; if (wrap_a !== 1'b0) begin errors++; $display("FAIL ping_wrap_len k=%0d got %b want 0", k, wrap_a); end
      cyc();
      checks++; if (led_a !== exp_led || upd_a !== 1'b1) begin errors++; $display("FAIL ping_led k=%0d got %h/%b want %h/1", k, led_a, upd_a, exp_led); end
      cyc();
      checks++; if (upd_a !== 1'b0 || addr_a !== pp_addr[k]) begin errors++; $display("FAIL ping_hold k=%0d got upd=%b addr=%0d want 0 %0d", k, upd_a, addr_a, pp_addr[k]); end
    end
  endtask

  task automatic test_en_hold();
    en_a = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      checks++; if (addr_a !== 3'd2 || led_a !== 8'h04 || upd_a !== 1'b0 || wrap_a !== 1'b0)
        begin errors++; $display("FAIL en_freeze e=%0d got addr=%0d led=%h upd=%b wrap=%b want 2 04 0 0", e, addr_a, led_a, upd_a, wrap_a); end
    end
    en_a = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      cyc();
      checks++; if (addr_a !== 3'd2) begin errors++; $display("FAIL en_resume_early i=%0d got %0d want 2", i, addr_a); end
    end
    cyc();
    checks++; if (addr_a !== 3'd3) begin errors++; $display("FAIL en_resume_step got %0d want 3", addr_a); end
    mode_a = 2'b11;
    cyc();
    cyc();
    checks++; if (led_a !== 8'h08 || upd_a !== 1'b1) begin errors++; $display("FAIL hold_inflight got %h/%b want 08/1", led_a, upd_a); end
    for (int i = 0; i < 20; i++) begin
      cyc();
      checks++; if (upd_a !== 1'b0 || wrap_a !== 1'b0 || addr_a !== 3'd3)
        begin errors++; $display("FAIL hold e=%0d got upd=%b wrap=%b addr=%0d want 0 0 3", e, upd_a, wrap_a, addr_a); end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp_addr;
    logic [7:0] exp_led;
    logic       exp_upd, exp_wrap;
    en_b    = 1'b1;
    mode_b  = 2'b00;
    rst_b_n = 1'b0;
    @(negedge clk);
    checks++; if (addr_b !== 3'd0 || led_b !== 8'h00) begin errors++; $display("FAIL b2b_rst got %0d/%h want 0/00", addr_b, led_b); end
    rst_b_n = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      exp_addr = 3'(n % 8);
      exp_wrap = (n % 8 == 0);
      exp_upd  = (n >= 2);
      exp_led  = (n >= 2) ? (8'h01 << ((n - 2) % 8)) : 8'h00;
      checks++; if (addr_b !== exp_addr) begin errors++; $display("FAIL b2b_addr n=%0d got %0d want %0d", n, addr_b, exp_addr); end
      checks++; if (wrap_b !== exp_wrap) begin errors++; $display("FAIL b2b_wrap n=%0d got %b want %b", n, wrap_b, exp_wrap); end
      checks++; if (upd_b !== exp_upd)   begin errors++; $display("FAIL b2b_upd n=%0d got %b want %b", n, upd_b, exp_upd); end
      checks++; if (led_b !== exp_led)   begin errors++; $display("FAIL b2b_led n=%0d got %h want %h", n, led_b, exp_led); end
    end
    en_b = 1'b0;
  endtask

  task automatic test_reset_mid();
    reset_a();
    while (e < 16) cyc();
    checks++; if (addr_a !== 3'd4 || led_a !== 8'h08 || valid_a !== 1'b1)
      begin errors++; $display("FAIL mid_pre got addr=%0d led=%h valid=%b want 4 08 1", addr_a, led_a, valid_a); end
    rst_a_n = 1'b0;
    #1;
    checks++; if (addr_a !== 3'd0 || led_a !== 8'h00 || valid_a !== 1'b0 || upd_a !== 1'b0 || wrap_a !== 1'b0)
      begin errors++; $display("FAIL mid_async got addr=%0d led=%h valid=%b upd=%b wrap=%b want 0 00 0 0 0", addr_a, led_a, valid_a, upd_a, wrap_a); end
    repeat (2) @(negedge clk);
    rst_a_n = 1'b1;
    e = 0;
    cyc();
    checks++; if (led_a !== 8'h00 || upd_a !== 1'b0) begin errors++; $display("FAIL mid_stale got %h/%b want 00/0", led_a, upd_a); end
    cyc();
    checks++; if (led_a !== 8'h01 || upd_a !== 1'b1) begin errors++; $display("FAIL mid_first got %h/%b want 01/1", led_a, upd_a); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_up();
    test_down();
    test_ping();
    test_en_hold();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
